// File: rtl/down_count_monitor_pkg.sv
// Shared types and constants for the ripple down-counter monitor.
package down_count_monitor_pkg;
  localparam int CNT_W   = 3;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] dec_mod(input logic [CNT_W-1:0] v);
    return v - 3'd1;
  endfunction
endpackage

// File: rtl/down_count_monitor_sync_stable_filter.sv
// Synchroniser chain plus stability filter for the asynchronous 3-bit counter bus.
module sync_stable_filter
  import down_count_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] din,
  output logic [CNT_W-1:0] value,
  output logic             stable
);
  localparam int RUN_W = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYC);

  logic [CNT_W-1:0]       sync_p [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] vld_p;
  logic [CNT_W-1:0]       last_p;
  logic [RUN_W-1:0]       run_p;
  logic [CNT_W-1:0]       s;

  assign s = sync_p[SYNC_STAGES-1];

  // Synchroniser stage; vld_p marks which flops hold post-reset samples so
  // stale reset zeros are never counted as a stable value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      vld_p <= '0;
    end else begin
      sync_p[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      vld_p <= {vld_p[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Stability stage: run length of identical synced samples, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_p <= '0;
      run_p  <= '0;
    end else if (vld_p[SYNC_STAGES-1]) begin
      if (s == last_p) begin
        if (run_p != RUN_MAX) run_p <= run_p + 1'b1;
      end else begin
        last_p <= s;
        run_p  <= RUN_W'(1);
      end
    end
  end

  assign value  = last_p;
  assign stable = (run_p == RUN_MAX);
endmodule

// File: rtl/down_count_monitor.sv
// Filters a ripple down-counter and tracks wraps; skip detection enabled by
// defining DOWN_COUNT_MONITOR_SKIP_CHECK_EN.
module down_count_monitor
  import down_count_monitor_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 2,
  parameter int WRAP_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   cnt_in,
  input  logic               clr,
  output logic [CNT_W-1:0]   cnt_val,
  output logic               cnt_vld,
  output logic               wrap,
  output logic [WRAP_W-1:0]  wrap_cnt,
  output logic               err,
  output logic [STATE_W-1:0] state
);
  logic [CNT_W-1:0]  fval;
  logic              fstable;
  logic              accept;
  state_t            state_q, nxt_state;
  logic [CNT_W-1:0]  nxt_val;
  logic              nxt_vld, nxt_wrap, nxt_err;
  logic [WRAP_W-1:0] nxt_wcnt;

  sync_stable_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CYC (STABLE_CYC)
  ) u_filter (
    .clk   (clk),
    .rst   (rst),
    .din   (cnt_in),
    .value (fval),
    .stable(fstable)
  );

  assign accept = fstable && ((fval != cnt_val) || (state_q == ST_IDLE));
  assign state  = state_q;

  always_comb begin
    nxt_state = state_q;
    nxt_val   = cnt_val;
    nxt_vld   = 1'b0;
    nxt_wrap  = 1'b0;
    nxt_wcnt  = wrap_cnt;
    nxt_err   = err;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          nxt_val   = fval;
          nxt_vld   = 1'b1;
          nxt_state = ST_TRACK;
        end
      end
      ST_TRACK: begin
        if (accept) begin
          nxt_val = fval;
          nxt_vld = 1'b1;
          if (fval == dec_mod(cnt_val)) begin
            if (cnt_val == '0) begin
              nxt_wrap = 1'b1;
              if (wrap_cnt != '1) nxt_wcnt = wrap_cnt + 1'b1;
            end
          end else begin
`ifdef DOWN_COUNT_MONITOR_SKIP_CHECK_EN
            nxt_err   = 1'b1;
            nxt_state = ST_ERROR;
`endif
          end
        end
      end
      ST_ERROR: begin
        if (accept) begin
          nxt_val = fval;
          nxt_vld = 1'b1;
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
    // clr overrides error and counter updates; a coincident wrap still pulses.
    if (clr) begin
      nxt_err  = 1'b0;
      nxt_wcnt = '0;
      if (nxt_state == ST_ERROR) nxt_state = ST_TRACK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_val  <= '0;
      cnt_vld  <= 1'b0;
      wrap     <= 1'b0;
      wrap_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state_q  <= nxt_state;
      cnt_val  <= nxt_val;
      cnt_vld  <= nxt_vld;
      wrap     <= nxt_wrap;
      wrap_cnt <= nxt_wcnt;
      err      <= nxt_err;
    end
  end
endmodule

// File: tb/tb_down_count_monitor.sv
// Directed bench for down_count_monitor (SYNC_STAGES=2, STABLE_CYC=2, WRAP_W=8).
module tb_down_count_monitor;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cnt_in;
  logic       clr;
  logic [2:0] cnt_val;
  logic       cnt_vld;
  logic       wrap;
  logic [7:0] wrap_cnt;
  logic       err;
  logic [1:0] state;

  int ntests = 0;
  int nfail  = 0;
  int nvld   = 0;
  int nwrap  = 0;
  int nseen1 = 0;
  int snap_vld, snap_wrap, snap_seen1;

  down_count_monitor #(
    .SYNC_STAGES(2),
    .STABLE_CYC (2),
    .WRAP_W     (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cnt_in  (cnt_in),
    .clr     (clr),
    .cnt_val (cnt_val),
    .cnt_vld (cnt_vld),
    .wrap    (wrap),
    .wrap_cnt(wrap_cnt),
    .err     (err),
    .state   (state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cnt_vld) nvld <= nvld + 1;
    if (wrap) nwrap <= nwrap + 1;
    if (cnt_vld && cnt_val == 3'd1) nseen1 <= nseen1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [2:0] v, input int n);
    cnt_in = v;
    tick(n);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; cnt_in = 3'd0;
    tick(2);
    chk("rst_cnt_val", cnt_val, 0);
    chk("rst_cnt_vld", cnt_vld, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_wrap_cnt", wrap_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_state", state, 0);

    // first acceptance after release: pulse on the 4th edge after the sampling edge
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("init_vld_early", cnt_vld, 0);
    end
    tick(1);
    chk("init_vld", cnt_vld, 1);
    chk("init_cnt_val", cnt_val, 0);
    chk("init_state", state, 1);
    tick(1);
    chk("init_vld_single", cnt_vld, 0);

    // full down sequence with two wraps
    snap_vld = nvld; snap_wrap = nwrap;
    feed(3'd7, 6);
    for (int k = 6; k >= 0; k--) feed(3'(k), 6);
    feed(3'd7, 6);
    chk("seq_vld_pulses", nvld - snap_vld, 9);
    chk("seq_wrap_pulses", nwrap - snap_wrap, 2);
    chk("seq_wrap_cnt", wrap_cnt, 2);
    chk("seq_err", err, 0);
    chk("seq_cnt_val", cnt_val, 7);

    // single-cycle glitch must be filtered
    for (int k = 6; k >= 3; k--) feed(3'(k), 6);
    chk("pre_glitch_val", cnt_val, 3);
    snap_vld = nvld; snap_seen1 = nseen1;
    feed(3'd1, 1);
    feed(3'd2, 8);
    chk("glitch_cnt_val", cnt_val, 2);
    chk("glitch_not_seen", nseen1 - snap_seen1, 0);
    chk("glitch_vld_pulses", nvld - snap_vld, 1);
    chk("glitch_err", err, 0);

    // skip 101 -> 010
    feed(3'd1, 6); feed(3'd0, 6); feed(3'd7, 6); feed(3'd6, 6); feed(3'd5, 6);
    chk("pre_skip_val", cnt_val, 5);
    chk("pre_skip_wrap_cnt", wrap_cnt, 3);
    feed(3'd2, 8);
    chk("skip_cnt_val", cnt_val, 2);
`ifdef DOWN_COUNT_MONITOR_SKIP_CHECK_EN
    chk("skip_err", err, 1);
    chk("skip_state", state, 2);
`else
    chk("skip_err", err, 0);
    chk("skip_state", state, 1);
`endif
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_err", err, 0);
    chk("clr_state", state, 1);
    chk("clr_wrap_cnt", wrap_cnt, 0);

    // clr coincident with a wrap: wrap pulses, count cleared
    feed(3'd1, 6); feed(3'd0, 6);
    cnt_in = 3'd7;
    tick(4);
    chk("clrwrap_vld_early", cnt_vld, 0);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clrwrap_wrap", wrap, 1);
    chk("clrwrap_wrap_cnt", wrap_cnt, 0);
    chk("clrwrap_cnt_val", cnt_val, 7);
    tick(2);
    chk("clrwrap_wrap_single", wrap, 0);

    // saturation over 260 wraps
    snap_wrap = nwrap;
    for (int w = 0; w < 260; w++) begin
      for (int k = 6; k >= 0; k--) feed(3'(k), 6);
      feed(3'd7, 6);
      if (w == 253) chk("wrap_cnt_254", wrap_cnt, 254);
      if (w == 254) chk("wrap_cnt_255", wrap_cnt, 255);
    end
    chk("sat_wrap_cnt", wrap_cnt, 255);
    chk("sat_wrap_pulses", nwrap - snap_wrap, 260);

    // reset in the middle of filtering a new value
    cnt_in = 3'd6;
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("midrst_cnt_val", cnt_val, 0);
    chk("midrst_vld", cnt_vld, 0);
    chk("midrst_wrap", wrap, 0);
    chk("midrst_wrap_cnt", wrap_cnt, 0);
    chk("midrst_err", err, 0);
    chk("midrst_state", state, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("restart_vld_early", cnt_vld, 0);
    end
    tick(1);
    chk("restart_vld", cnt_vld, 1);
    chk("restart_cnt_val", cnt_val, 6);
    chk("restart_state", state, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/down_count_monitor.md
DOWN_COUNT_MONITOR -- requirements
Module: down_count_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops on cnt_in (min 2) SHALL be provided.
REQ-002 Parameter STABLE_CYC, default 2, consecutive identical synced samples required to accept a value (min 1) SHALL be provided.
REQ-003 Parameter WRAP_W, default 8, width of wrap_cnt SHALL be provided.
REQ-004 clk  in  1  single clock; all state on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cnt_in  in  3  raw output of the 3-bit ripple down counter; asynchronous, may glitch.
REQ-007 clr  in  1  synchronous clear of err and wrap_cnt.
REQ-008 cnt_val  out  3  last accepted (filtered) counter value.
REQ-009 cnt_vld  out  1  one-cycle pulse when cnt_val is updated.
REQ-010 wrap  out  1  one-cycle pulse on accepted 000 -> 111 transition.
REQ-011 wrap_cnt  out  WRAP_W  saturating count of wraps.
REQ-012 err  out  1  sticky skip error (see Configuration).
REQ-013 state  out  2  FSM state, debug only.

Function
REQ-014 cnt_in SHALL pass through SYNC_STAGES flops; the last stage is the synced value s.
REQ-015 A value SHALL be accepted when s has been identical for STABLE_CYC consecutive clk samples and (differs from cnt_val, or FSM is IDLE).
REQ-016 Latency: a single change on cnt_in, held, SHALL produce cnt_vld exactly SYNC_STAGES+STABLE_CYC cycles after the first edge that samples it; cnt_val updates in the same cycle.
REQ-017 Glitches shorter than STABLE_CYC synced cycles SHALL never reach cnt_val.
REQ-018 FSM states: IDLE=0, TRACK=1, ERROR=2; encoding 3 unused and SHALL recover to IDLE.
REQ-019 IDLE: first accepted value loads cnt_val, pulses cnt_vld, no wrap/err check, -> TRACK.
REQ-020 TRACK: accepted v == (cnt_val-1) mod 8 is normal; if cnt_val==000 and v==111, wrap pulses and wrap_cnt increments, saturating at all-ones.
REQ-021 TRACK: accepted v that is not cnt_val-1 mod 8 is a skip; handled per Configuration.
REQ-022 ERROR: cnt_val/cnt_vld keep tracking; wrap and wrap_cnt frozen; -> TRACK only on clr.
REQ-023 clr: next cycle err=0, wrap_cnt=0, ERROR -> TRACK; clr coincident with a wrap: wrap still pulses, wrap_cnt=0 (clr wins).
REQ-024 cnt_vld and wrap SHALL be registered single-cycle pulses, never asserted two cycles in a row for one acceptance.

Reset
REQ-025 rst SHALL dominate clr and all events; at the edge with rst=1: sync flops=0, stability count=0, cnt_val=000, cnt_vld=0, wrap=0, wrap_cnt=0, err=0, state=IDLE.
REQ-026 Reset mid-operation SHALL discard any partially filtered value; tracking restarts from IDLE.

Configuration
REQ-027 Macro DOWN_COUNT_MONITOR_SKIP_CHECK_EN defined: a skip sets err=1 (sticky), cnt_val takes v, cnt_vld pulses, FSM -> ERROR.
REQ-028 Macro undefined: skip accepted silently in TRACK, err tied 0, ERROR unreachable; all other behaviour identical.

Structure
REQ-029 Package down_count_monitor_pkg SHALL hold the state enum, CNT_W=3 and the state width constant.
REQ-030 Sub-module sync_stable_filter SHALL implement synchroniser plus stability filter (REQ-014..017), outputting value and a stable strobe.

Verification (SYNC_STAGES=2, STABLE_CYC=2)
REQ-031 rst=1 two cycles, cnt_in=000 -> cnt_vld pulses 4 cycles after release, cnt_val=000, state=TRACK.
REQ-032 From 000, feed 111,110,...,000,111 each held 6 cycles -> 9 cnt_vld pulses, 2 wrap pulses, wrap_cnt=2, err=0.
REQ-033 cnt_in 011 held, then 001 for 1 cycle, then 010 held -> cnt_val goes 011 -> 010, 001 never seen, err=0.
REQ-034 cnt_val=101 then cnt_in=010 held -> with macro err=1, state=ERROR; clr 1 cycle -> err=0, TRACK, wrap_cnt=0; without macro err stays 0.
REQ-035 Drive 260 wraps -> wrap_cnt=255 saturated; assert rst mid-filter -> next cycle all outputs 0, state=IDLE.
